pcie_byte_striper: RTL and testbench
====================================

# pcie_byte_striper

Parametrised byte-striping stage for the PCIe datapath. It accepts a byte stream over a valid/ready handshake and distributes consecutive bytes round-robin across a configurable number of active lanes. Each lane is buffered by its own FIFO, and every lane is drained independently by its downstream serializer. It replaces the fixed single-lane 8-bit path and sits between the transaction-side data source and the per-lane serializers.

## Interface
- `DATA_W`, 8: bits per symbol.
- `LANES`, 4: physical lane count; power of two, 1..16.
- `FIFO_DEPTH`, 4: entries per lane FIFO; power of two, ≥2.
- `CLK` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `cfg_lanes` input clog2(LANES)+1: number of active lanes (1..LANES). Latched only while `reset`=0.
- `in_valid` input 1: upstream byte valid.
- `in_data` input DATA_W: upstream byte.
- `in_ready` output 1: the striper accepts `in_data` this cycle.
- `lane_data` output LANES*DATA_W: FIFO head of each lane; lane i occupies bits [i*DATA_W +: DATA_W].
- `lane_valid` output LANES: lane FIFO is non-empty.
- `lane_pop` input LANES: downstream consumes the head of lane i.
- `lane_full` output LANES: lane FIFO holds FIFO_DEPTH entries.
- `err_underflow` output 1: sticky; set by a pop on an empty lane.
- `err_cfg` output 1: sticky; set when the latched `cfg_lanes` is 0 or greater than LANES.

## Operation
- Active lane count N = the `cfg_lanes` value latched during reset. Invalid values set `err_cfg` and force N=1.
- Write pointer `wr_lane` ranges over 0..N-1.
- `in_ready` = !`lane_full[wr_lane]`. This path is combinational from registered state only; `in_valid` never feeds `in_ready`.
- Transfer occurs when `in_valid` and `in_ready` are both high. On a transfer:
  - `in_data` is pushed into FIFO[`wr_lane`].
  - `wr_lane` advances to `wr_lane`+1, wrapping from N-1 to 0.
- With no transfer, `wr_lane` holds. Strict order is enforced: lane k+1 never receives a byte before lane k.
- Lanes ≥N are never written; their `lane_valid` and `lane_full` stay 0.
- Lane FIFOs are show-ahead: `lane_data` always shows the oldest entry. A pop when `lane_valid`=1 removes that entry.
- A pop on an empty lane is ignored and sets `err_underflow`.
- Push and pop on the same lane in the same cycle:
  - Non-full, non-empty FIFO: occupancy is unchanged and both operations take effect.
  - Full FIFO: the push is blocked by `in_ready`=0 and only the pop occurs. `in_ready` rises the next cycle.
  - Empty FIFO: only the push occurs; the pop is an underflow.
- Pointer arithmetic is clog2(FIFO_DEPTH)+1 bits. Full = equal indices with opposite wrap bits; empty = pointers equal.
- Sticky errors are cleared only by reset.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after reset deasserts. `lane_valid`=0, `lane_full`=0, `lane_data`=0, both error flags 0. `wr_lane`=0 and all FIFOs are empty.
- Reset mid-operation discards all buffered data on the next edge; partial stripes are lost.
- Latency: a byte accepted at edge t appears on `lane_data`/`lane_valid` after edge t (visible in cycle t+1).
- A pop at edge t exposes the next entry, or drops `lane_valid`, after edge t.
- Throughput: one byte per cycle while the target lane is not full. Sustained rate is limited by the slowest active lane.
- `lane_full` is registered and updates on the same edge as the occupancy change.

## Structure
- Shared package `pcie_pkg` holds:
  - default `DATA_W`, `LANES`, `FIFO_DEPTH`
  - the `clog2` helper
  - the lane-index width constant
- Sub-module `pcie_lane_fifo`: a parametrised DATA_W×FIFO_DEPTH show-ahead FIFO with push, pop, full and empty signals. It is instantiated LANES times in a generate loop.
- The top level holds the config latch, `wr_lane` counter, `in_ready` mux, and error logic.

## Test plan
- Defaults, `cfg_lanes`=4, push 0x10..0x17 with all pops held low:
  - lane0 holds 0x10, 0x14; lane1 0x11, 0x15; lane2 0x12, 0x16; lane3 0x13, 0x17.
  - `lane_valid`=4'b1111 one cycle after the first byte of each lane.
- `cfg_lanes`=2, push 0xA0..0xA5: lane0 = A0, A2, A4; lane1 = A1, A3, A5; lanes 2–3 stay invalid.
- Backpressure, `cfg_lanes`=1, `FIFO_DEPTH`=4, no pops:
  - `in_ready` drops after the 4th byte.
  - A same-cycle `in_valid` byte 0x55 is not accepted.
  - Pop one entry: `in_ready`=1 next cycle and 0x55 is then accepted.
- Simultaneous push/pop on a half-full lane over 20 cycles: occupancy is constant and byte order is preserved.
- Pop lane3 while empty → `err_underflow`=1 and stays 1 until reset. Latching `cfg_lanes`=0 → `err_cfg`=1 and N=1.
- Assert `reset`=0 with 3 entries buffered → all `lane_valid`=0 and `in_ready`=0 next cycle. After release, the first byte goes to lane0.

Source files
------------

// File: rtl/pcie_pkg.sv
// Shared defaults and helpers for the PCIe byte-striping datapath.
package pcie_pkg;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_LANES      = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  // Lane-index width, never narrower than one bit so single-lane builds stay legal.
  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? clog2(lanes) : 1;
  endfunction

  localparam int unsigned LANE_IDX_W = lane_idx_w(DEF_LANES);

endpackage

// File: rtl/pcie_lane_fifo.sv
// Show-ahead per-lane FIFO; the head entry is always visible on rdata_o, zero when empty.
module pcie_lane_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  import pcie_pkg::*;

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are masked by empty_o until written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/pcie_byte_striper.sv
// Round-robin byte striper: distributes an input byte stream over N active lane FIFOs.
module pcie_byte_striper
  import pcie_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [clog2(LANES):0]   cfg_lanes,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic [LANES*DATA_W-1:0] lane_data,
  output logic [LANES-1:0]        lane_valid,
  input  logic [LANES-1:0]        lane_pop,
  output logic [LANES-1:0]        lane_full,
  output logic                    err_underflow,
  output logic                    err_cfg
);

  localparam int unsigned CFG_W  = clog2(LANES) + 1;
  localparam int unsigned LIDX_W = lane_idx_w(LANES);

  logic              run_q;
  logic [LIDX_W-1:0] wr_lane_q, wr_lane_d;
  logic [LIDX_W-1:0] last_q, last_d;
  logic              cfg_bad_q, cfg_bad_d;
  logic              err_cfg_q, err_cfg_d;
  logic              err_uf_q, err_uf_d;
  logic              xfer;
  logic [LANES-1:0]  push;
  logic [LANES-1:0]  empty;

  // run_q keeps in_ready low while in reset without routing the reset pin into the ready path.
  assign in_ready      = run_q & ~lane_full[wr_lane_q];
  assign lane_valid    = ~empty;
  assign err_underflow = err_uf_q;
  assign err_cfg       = err_cfg_q;

  always_comb begin
    cfg_bad_d = (cfg_lanes == '0) || (cfg_lanes > CFG_W'(LANES));
    last_d    = cfg_bad_d ? '0 : LIDX_W'(cfg_lanes - CFG_W'(1));

    xfer      = in_valid & in_ready;
    wr_lane_d = wr_lane_q;
    if (xfer) begin
      wr_lane_d = (wr_lane_q == last_q) ? '0 : wr_lane_q + LIDX_W'(1);
    end

    for (int unsigned i = 0; i < LANES; i++) begin
      push[i] = xfer && (wr_lane_q == LIDX_W'(i));
    end

    err_uf_d  = err_uf_q | (|(lane_pop & empty));
    err_cfg_d = err_cfg_q | cfg_bad_q;
  end

  // Config is latched on every reset edge; a bad value shows on err_cfg once reset is released.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      run_q     <= 1'b0;
      wr_lane_q <= '0;
      err_uf_q  <= 1'b0;
      err_cfg_q <= 1'b0;
      cfg_bad_q <= cfg_bad_d;
      last_q    <= last_d;
    end else begin
      run_q     <= 1'b1;
      wr_lane_q <= wr_lane_d;
      err_uf_q  <= err_uf_d;
      err_cfg_q <= err_cfg_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pcie_lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (reset),
      .push_i  (push[g]),
      .pop_i   (lane_pop[g]),
      .wdata_i (in_data),
      .rdata_o (lane_data[g*DATA_W +: DATA_W]),
      .full_o  (lane_full[g]),
      .empty_o (empty[g])
    );
  end

endmodule

// File: tb/tb_pcie_byte_striper.sv
// Directed bench for pcie_byte_striper at default parameters (8-bit, 4 lanes, depth 4).
module tb_pcie_byte_striper;

  logic        CLK = 1'b0;
  logic        reset;
  logic [2:0]  cfg_lanes;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic [3:0]  lane_pop;
  logic [3:0]  lane_full;
  logic        err_underflow;
  logic        err_cfg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  pcie_byte_striper dut (
    .CLK           (CLK),
    .reset         (reset),
    .cfg_lanes     (cfg_lanes),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .lane_data     (lane_data),
    .lane_valid    (lane_valid),
    .lane_pop      (lane_pop),
    .lane_full     (lane_full),
    .err_underflow (err_underflow),
    .err_cfg       (err_cfg)
  );

  typedef struct {
    logic        newp;
    logic [2:0]  cfg;
    logic        iv;
    logic [7:0]  d;
    logic [3:0]  pop;
    logic        rdy;
    logic [3:0]  vld;
    logic [3:0]  full;
    logic [31:0] data;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic newp, input logic [2:0] cfg, input logic iv,
                              input logic [7:0] d, input logic [3:0] pop, input logic rdy,
                              input logic [3:0] vld, input logic [3:0] full,
                              input logic [31:0] data);
    vec_t v;
    v.newp = newp; v.cfg = cfg; v.iv = iv; v.d = d; v.pop = pop;
    v.rdy = rdy; v.vld = vld; v.full = full; v.data = data;
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic [3:0] pop);
    in_valid = iv;
    in_data  = d;
    lane_pop = pop;
  endtask

  task automatic do_reset(input logic [2:0] cfg, input logic exp_cfg_err);
    reset = 1'b0;
    cfg_lanes = cfg;
    drive(1'b0, 8'h00, 4'b0000);
    step();
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_valid", {28'd0, lane_valid}, 32'd0);
    check("rst_full", {28'd0, lane_full}, 32'd0);
    check("rst_data", lane_data, 32'd0);
    check("rst_err_uf", {31'd0, err_underflow}, 32'd0);
    check("rst_err_cfg", {31'd0, err_cfg}, 32'd0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_err_cfg", {31'd0, err_cfg}, {31'd0, exp_cfg_err});
  endtask

  initial begin
    logic [7:0] q[$];

    reset = 1'b0;
    cfg_lanes = 3'd4;
    drive(1'b0, 8'h00, 4'b0000);

    // 4 lanes: 0x10..0x17 striped round-robin, then drained
    vq.push_back(mk(1, 3'd4, 1, 8'h10, 4'b0000, 1, 4'b0001, 4'b0000, 32'h0000_0010));
    vq.push_back(mk(0, 3'd4, 1, 8'h11, 4'b0000, 1, 4'b0011, 4'b0000, 32'h0000_1110));
    vq.push_back(mk(0, 3'd4, 1, 8'h12, 4'b0000, 1, 4'b0111, 4'b0000, 32'h0012_1110));
    vq.push_back(mk(0, 3'd4, 1, 8'h13, 4'b0000, 1, 4'b1111, 4'b0000, 32'h1312_1110));
    vq.push_back(mk(0, 3'd4, 1, 8'h14, 4'b0000, 1, 4'b1111, 4'b0000, 32'h1312_1110));
    vq.push_back(mk(0, 3'd4, 1, 8'h15, 4'b0000, 1, 4'b1111, 4'b0000, 32'h1312_1110));
    vq.push_back(mk(0, 3'd4, 1, 8'h16, 4'b0000, 1, 4'b1111, 4'b0000, 32'h1312_1110));
    vq.push_back(mk(0, 3'd4, 1, 8'h17, 4'b0000, 1, 4'b1111, 4'b0000, 32'h1312_1110));
    vq.push_back(mk(0, 3'd4, 0, 8'h00, 4'b1111, 1, 4'b1111, 4'b0000, 32'h1716_1514));
    vq.push_back(mk(0, 3'd4, 0, 8'h00, 4'b1111, 1, 4'b0000, 4'b0000, 32'h0000_0000));
    // 2 lanes: A0..A5
    vq.push_back(mk(1, 3'd2, 1, 8'hA0, 4'b0000, 1, 4'b0001, 4'b0000, 32'h0000_00A0));
    vq.push_back(mk(0, 3'd2, 1, 8'hA1, 4'b0000, 1, 4'b0011, 4'b0000, 32'h0000_A1A0));
    vq.push_back(mk(0, 3'd2, 1, 8'hA2, 4'b0000, 1, 4'b0011, 4'b0000, 32'h0000_A1A0));
    vq.push_back(mk(0, 3'd2, 1, 8'hA3, 4'b0000, 1, 4'b0011, 4'b0000, 32'h0000_A1A0));
    vq.push_back(mk(0, 3'd2, 1, 8'hA4, 4'b0000, 1, 4'b0011, 4'b0000, 32'h0000_A1A0));
    vq.push_back(mk(0, 3'd2, 1, 8'hA5, 4'b0000, 1, 4'b0011, 4'b0000, 32'h0000_A1A0));
    vq.push_back(mk(0, 3'd2, 0, 8'h00, 4'b0011, 1, 4'b0011, 4'b0000, 32'h0000_A3A2));
    vq.push_back(mk(0, 3'd2, 0, 8'h00, 4'b0011, 1, 4'b0011, 4'b0000, 32'h0000_A5A4));
    vq.push_back(mk(0, 3'd2, 0, 8'h00, 4'b0011, 1, 4'b0000, 4'b0000, 32'h0000_0000));
    // 1 lane backpressure: fill, blocked 0x55, pop releases, 0x55 accepted
    vq.push_back(mk(1, 3'd1, 1, 8'h01, 4'b0000, 1, 4'b0001, 4'b0000, 32'h0000_0001));
    vq.push_back(mk(0, 3'd1, 1, 8'h02, 4'b0000, 1, 4'b0001, 4'b0000, 32'h0000_0001));
    vq.push_back(mk(0, 3'd1, 1, 8'h03, 4'b0000, 1, 4'b0001, 4'b0000, 32'h0000_0001));
    vq.push_back(mk(0, 3'd1, 1, 8'h04, 4'b0000, 0, 4'b0001, 4'b0001, 32'h0000_0001));
    vq.push_back(mk(0, 3'd1, 1, 8'h55, 4'b0000, 0, 4'b0001, 4'b0001, 32'h0000_0001));
    vq.push_back(mk(0, 3'd1, 1, 8'h55, 4'b0001, 1, 4'b0001, 4'b0000, 32'h0000_0002));
    vq.push_back(mk(0, 3'd1, 1, 8'h55, 4'b0000, 0, 4'b0001, 4'b0001, 32'h0000_0002));
    vq.push_back(mk(0, 3'd1, 0, 8'h00, 4'b0001, 1, 4'b0001, 4'b0000, 32'h0000_0003));
    vq.push_back(mk(0, 3'd1, 0, 8'h00, 4'b0001, 1, 4'b0001, 4'b0000, 32'h0000_0004));
    vq.push_back(mk(0, 3'd1, 0, 8'h00, 4'b0001, 1, 4'b0001, 4'b0000, 32'h0000_0055));
    vq.push_back(mk(0, 3'd1, 0, 8'h00, 4'b0001, 1, 4'b0000, 4'b0000, 32'h0000_0000));

    foreach (vq[i]) begin
      if (vq[i].newp) do_reset(vq[i].cfg, 1'b0);
      drive(vq[i].iv, vq[i].d, vq[i].pop);
      step();
      check($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, vq[i].rdy});
      check($sformatf("vec%0d_valid", i), {28'd0, lane_valid}, {28'd0, vq[i].vld});
      check($sformatf("vec%0d_full", i), {28'd0, lane_full}, {28'd0, vq[i].full});
      check($sformatf("vec%0d_data", i), lane_data, vq[i].data);
    end
    drive(1'b0, 8'h00, 4'b0000);
    check("no_underflow_yet", {31'd0, err_underflow}, 32'd0);

    // Simultaneous push/pop on a half-full single lane
    do_reset(3'd1, 1'b0);
    q = {};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 8'hB0 + 8'(k), 4'b0000);
      q.push_back(8'hB0 + 8'(k));
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 8'hC0 + 8'(k), 4'b0001);
      void'(q.pop_front());
      q.push_back(8'hC0 + 8'(k));
      step();
      check($sformatf("pp%0d_head", k), lane_data, {24'd0, q[0]});
      check($sformatf("pp%0d_ready", k), {27'd0, in_ready, lane_full}, 32'h10);
    end
    drive(1'b0, 8'h00, 4'b0001);
    step();
    check("pp_drain_head", lane_data, 32'h0000_00D3);
    step();
    check("pp_drain_empty", {28'd0, lane_valid}, 32'd0);
    drive(1'b0, 8'h00, 4'b0000);

    // Underflow is sticky; then reset mid-operation with an invalid config
    do_reset(3'd4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'hC0 + 8'(k), 4'b0000);
      step();
    end
    drive(1'b0, 8'h00, 4'b1000);
    step();
    drive(1'b0, 8'h00, 4'b0000);
    check("uf_set", {31'd0, err_underflow}, 32'd1);
    check("uf_valid", {28'd0, lane_valid}, 32'h7);
    check("uf_data", lane_data, 32'h00C2_C1C0);
    step(); step(); step();
    check("uf_sticky", {31'd0, err_underflow}, 32'd1);

    reset = 1'b0;
    cfg_lanes = 3'd0;
    step();
    check("midrst_valid", {28'd0, lane_valid}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_uf_clr", {31'd0, err_underflow}, 32'd0);
    check("midrst_data", lane_data, 32'd0);
    step();
    reset = 1'b1;
    step();
    check("cfg0_err", {31'd0, err_cfg}, 32'd1);
    check("cfg0_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 8'hD0, 4'b0000);
    step();
    check("cfg0_first_lane0", {28'd0, lane_valid}, 32'h1);
    check("cfg0_first_data", lane_data, 32'h0000_00D0);
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 8'hD0 + 8'(k), 4'b0000);
      step();
    end
    drive(1'b0, 8'h00, 4'b0000);
    check("cfg0_n1_valid", {28'd0, lane_valid}, 32'h1);
    check("cfg0_n1_full", {28'd0, lane_full}, 32'h1);
    check("cfg0_n1_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("cfg0_err_sticky", {31'd0, err_cfg}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
